// File: rtl/wb_master_ctrl.sv
// wb_master_ctrl
//   Wishbone classic single-transfer initiator. Each accepted command becomes
//   exactly one Wishbone read or write. The result is returned on a
//   valid/ready response channel. A bounded wait-for-ack timeout stops an
//   unresponsive slave from hanging the bus.
//
// Parameters
//   TIMEOUT_CYC  number of bus cycles to wait for ack before aborting
//                (0 = wait forever)
//
// Ports
//   wb_clk_i, wb_rst_i        clock; synchronous active-high reset
//   cmd_valid / cmd_ready     command handshake
//   cmd_we/adr/dat/sel        command payload (write flag, byte address,
//                             write data, byte enables)
//   rsp_valid / rsp_ready     response handshake
//   rsp_dat, rsp_err          read data (0 for writes and on error);
//                             timeout flag
//   busy                      controller is not idle
//   wbm_*_o / wbm_*_i         Wishbone classic master interface
module wb_master_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        busy,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  // A zero timeout still needs a 1-bit counter so the declarations stay legal.
  localparam int unsigned CNT_W = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cyc_q, cyc_d;
  logic               we_q, we_d;
  logic [3:0]         sel_q, sel_d;
  logic [31:0]        adr_q, adr_d;
  logic [31:0]        wdat_q, wdat_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_dat_q, rsp_dat_d;
  logic               rsp_err_q, rsp_err_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    wdat_d      = wdat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d = BUS;
          cyc_d   = 1'b1;
          we_d    = cmd_we;
          sel_d   = cmd_sel;
          adr_d   = cmd_adr;
          wdat_d  = cmd_dat;
          cnt_d   = '0;
        end
      end
      BUS: begin
        // ack has priority over a timeout that expires in the same cycle
        if (wbm_ack_i) begin
          state_d     = RESP;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_dat_d   = we_q ? '0 : wbm_dat_i;
        end else if ((TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST)) begin
          state_d     = RESP;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_dat_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        cyc_d       = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      wdat_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      wdat_q      <= wdat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready = (state_q == IDLE) && !wb_rst_i;
  assign busy      = (state_q != IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = wdat_q;

endmodule

// File: tb/tb_wb_master_ctrl.sv
// tb_wb_master_ctrl
//   Directed testbench for wb_master_ctrl (TIMEOUT_CYC = 16). Inputs are
//   driven and outputs sampled on the falling clock edge.
module tb_wb_master_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] rsp_dat;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;

  int  n_checks = 0;
  int  n_pass   = 0;
  time t_first, t0;

  wb_master_ctrl #(.TIMEOUT_CYC(16)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_adr  (cmd_adr),
    .cmd_dat  (cmd_dat),
    .cmd_sel  (cmd_sel),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_dat  (rsp_dat),
    .rsp_err  (rsp_err),
    .busy     (busy),
    .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o),
    .wbm_we_o (wbm_we_o),
    .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i),
    .wbm_dat_i(wbm_dat_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // One full transfer: issue command, answer the bus (ack in BUS cycle
  // ack_at, -1 = never), hold rsp_ready low for rdy_hold cycles, then consume.
  task automatic xfer(input string tag, input logic we, input logic [31:0] adr,
                      input logic [31:0] dat, input logic [3:0] sel, input int ack_at,
                      input logic [31:0] rdat, input int rdy_hold, input int exp_len,
                      input logic [31:0] exp_dat, input logic exp_err);
    int   len;
    logic ok;
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_we = ~we; cmd_adr = ~adr; cmd_dat = ~dat; cmd_sel = ~sel;
    t_first = $time;
    len = 0;
    ok  = 1'b1;
    while (wbm_cyc_o === 1'b1 && len < 100) begin
      if (wbm_stb_o !== 1'b1 || wbm_we_o !== we || wbm_adr_o !== adr ||
          wbm_dat_o !== dat || wbm_sel_o !== sel || busy !== 1'b1 || cmd_ready !== 1'b0)
        ok = 1'b0;
      wbm_dat_i = rdat;
      wbm_ack_i = (len == ack_at);
      len++;
      @(negedge clk);
    end
    wbm_ack_i = 1'b0;
    wbm_dat_i = 32'hDEAD_BEEF;
    check({tag, "_cyc_len"}, 32'(len), 32'(exp_len));
    check({tag, "_bus_stable"}, {31'd0, ok}, 32'd1);
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    check({tag, "_rsp_dat"}, rsp_dat, exp_dat);
    check({tag, "_rsp_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    for (int i = 0; i < rdy_hold; i++) begin
      cmd_valid = 1'b1;
      @(negedge clk);
      check({tag, "_hold_rsp"}, {rsp_valid, rsp_err, cmd_ready, wbm_cyc_o},
            {1'b1, exp_err, 1'b0, 1'b0});
      check({tag, "_hold_dat"}, rsp_dat, exp_dat);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_idle"}, {29'd0, rsp_valid, busy, cmd_ready}, 32'b001);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
    cmd_sel = '0; rsp_ready = 1'b0; wbm_ack_i = 1'b0; wbm_dat_i = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_bus", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o}, 32'd0);
    check("rst_adr_dat", wbm_adr_o | wbm_dat_o, 32'd0);
    check("rst_rsp", {rsp_valid, rsp_err, busy, cmd_ready}, 32'd0);
    check("rst_rsp_dat", rsp_dat, 32'd0);
    rst = 1'b0;
    #1 check("rst_release_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);

    // write, ack after 2 wait cycles
    xfer("wr", 1'b1, 32'h3000_0004, 32'hA5A5_5A5A, 4'hF, 2, 32'hDEAD_BEEF, 0,
         3, 32'h0, 1'b0);

    // back-to-back zero-wait reads, 3 cycles apart
    xfer("rd0", 1'b0, 32'h3000_0010, 32'h0, 4'hF, 0, 32'h1234_5678, 0,
         1, 32'h1234_5678, 1'b0);
    t0 = t_first;
    xfer("rd1", 1'b0, 32'h3000_0014, 32'h0, 4'h3, 0, 32'h8765_4321, 0,
         1, 32'h8765_4321, 1'b0);
    check("b2b_period", 32'(t_first - t0), 32'd30);

    // timeout with no ack
    xfer("tmo", 1'b0, 32'h3000_0020, 32'h0, 4'hF, -1, 32'h55AA_55AA, 0,
         16, 32'h0, 1'b1);

    // rsp_ready held low for 5 cycles with cmd_valid asserted
    xfer("hold", 1'b0, 32'h3000_0030, 32'h0, 4'hC, 1, 32'hCAFE_F00D, 5,
         2, 32'hCAFE_F00D, 1'b0);

    // ack arriving in the same cycle as the timeout
    xfer("tmo_ack", 1'b0, 32'h3000_0040, 32'h0, 4'hF, 15, 32'h0BAD_C0DE, 0,
         16, 32'h0BAD_C0DE, 1'b0);

    // reset pulse during BUS
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0050; cmd_dat = 32'h1;
    cmd_sel = 4'h1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("rstbus_cyc_before", {31'd0, wbm_cyc_o}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rstbus_abort", {wbm_cyc_o, wbm_stb_o, rsp_valid, busy, cmd_ready}, 32'd0);
    rst = 1'b0;
    #1 check("rstbus_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);

    // reset while a response is pending discards it
    cmd_valid = 1'b1; cmd_we = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    wbm_ack_i = 1'b1; wbm_dat_i = 32'h7777_7777;
    @(negedge clk);
    wbm_ack_i = 1'b0;
    check("rstresp_pending", {31'd0, rsp_valid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstresp_discard", {rsp_valid, busy, wbm_cyc_o}, 32'd0);
    @(negedge clk);

    // stray ack in IDLE
    wbm_ack_i = 1'b1;
    repeat (2) @(negedge clk);
    wbm_ack_i = 1'b0;
    check("stray_ack", {rsp_valid, busy, wbm_cyc_o, cmd_ready}, 32'b0001);
    @(negedge clk);
    check("stray_ack_after", {28'd0, rsp_valid, busy, wbm_cyc_o, cmd_ready}, 32'b0001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
